// File: rtl/tx_parity.sv
// UART transmit parity generator: captures the parity of the data word on a load
// strobe and holds it stable while the serializer shifts the frame out.
module tx_parity #(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  parity_load,
  output logic                  parity_out,
  output logic                  parity_valid
);

  typedef enum logic [1:0] {
    MODE_EVEN  = 2'd0,
    MODE_ODD   = 2'd1,
    MODE_MARK  = 2'd2,
    MODE_SPACE = 2'd3
  } mode_t;

  // Out-of-range mode values fall back to even parity.
  localparam mode_t MODE = (PARITY_MODE >= 0 && PARITY_MODE <= 3)
                           ? mode_t'(PARITY_MODE[1:0]) : MODE_EVEN;

  logic next_parity;

  always_comb begin
    next_parity = 1'b0;
    unique case (MODE)
      MODE_EVEN:  next_parity = ^data;
      MODE_ODD:   next_parity = ~(^data);
      MODE_MARK:  next_parity = 1'b1;
      MODE_SPACE: next_parity = 1'b0;
      default:    next_parity = ^data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      parity_out   <= 1'b0;
      parity_valid <= 1'b0;
    end else if (parity_load) begin
      parity_out   <= next_parity;
      parity_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_parity.sv
// Bench for tx_parity: several parameterisations share one stimulus stream and are
// compared each cycle against a count-of-ones reference model.
module tb_tx_parity;

  localparam int NINST = 6;
  localparam int MODES  [NINST] = '{0, 1, 2, 3, 7, 1};
  localparam int WIDTHS [NINST] = '{8, 8, 8, 8, 8, 5};

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       data;
  logic             parity_load;
  logic [NINST-1:0] pout;
  logic [NINST-1:0] pval;

  logic [NINST-1:0] exp_out;
  logic             exp_valid;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  tx_parity #(.DATA_WIDTH(8), .PARITY_MODE(0)) u_even (
    .clk(clk), .reset(reset), .data(data), .parity_load(parity_load),
    .parity_out(pout[0]), .parity_valid(pval[0]));
  tx_parity #(.DATA_WIDTH(8), .PARITY_MODE(1)) u_odd (
    .clk(clk), .reset(reset), .data(data), .parity_load(parity_load),
    .parity_out(pout[1]), .parity_valid(pval[1]));
  tx_parity #(.DATA_WIDTH(8), .PARITY_MODE(2)) u_mark (
    .clk(clk), .reset(reset), .data(data), .parity_load(parity_load),
    .parity_out(pout[2]), .parity_valid(pval[2]));
  tx_parity #(.DATA_WIDTH(8), .PARITY_MODE(3)) u_space (
    .clk(clk), .reset(reset), .data(data), .parity_load(parity_load),
    .parity_out(pout[3]), .parity_valid(pval[3]));
  tx_parity #(.DATA_WIDTH(8), .PARITY_MODE(7)) u_illegal (
    .clk(clk), .reset(reset), .data(data), .parity_load(parity_load),
    .parity_out(pout[4]), .parity_valid(pval[4]));
  tx_parity #(.DATA_WIDTH(5), .PARITY_MODE(1)) u_odd5 (
    .clk(clk), .reset(reset), .data(data[4:0]), .parity_load(parity_load),
    .parity_out(pout[5]), .parity_valid(pval[5]));

  function automatic logic ref_parity(int mode, int width, logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < width; i++) ones += int'(d[i]);
    case (mode)
      1:       return (ones % 2) == 0;
      2:       return 1'b1;
      3:       return 1'b0;
      default: return (ones % 2) == 1;
    endcase
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply inputs, advance one edge, update the model, then compare just after the edge.
  task automatic cycle(input logic r, input logic ld, input logic [7:0] d, input string tag);
    reset       = r;
    parity_load = ld;
    data        = d;
    @(posedge clk);
    if (!r) begin
      exp_out   = '0;
      exp_valid = 1'b0;
    end else if (ld) begin
      for (int k = 0; k < NINST; k++) exp_out[k] = ref_parity(MODES[k], WIDTHS[k], d);
      exp_valid = 1'b1;
    end
    #1;
    for (int k = 0; k < NINST; k++) begin
      check($sformatf("%s out[%0d]", tag, k), pout[k], exp_out[k]);
      check($sformatf("%s valid[%0d]", tag, k), pval[k], exp_valid);
    end
  endtask

  initial begin
    exp_out     = '0;
    exp_valid   = 1'b0;
    reset       = 1'b0;
    parity_load = 1'b1;
    data        = 8'h80;
    #2;

    cycle(1'b0, 1'b1, 8'h80, "reset1");
    cycle(1'b0, 1'b1, 8'h80, "reset2");
    cycle(1'b1, 1'b1, 8'b1010_1010, "even_load");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'hFF, "hold");
    cycle(1'b1, 1'b1, 8'b1000_0000, "odd_ones");
    cycle(1'b1, 1'b1, 8'h00, "zero_ones");
    cycle(1'b1, 1'b1, 8'h80, "set_one");
    cycle(1'b0, 1'b1, 8'h01, "reset_prio");
    cycle(1'b1, 1'b0, 8'h01, "valid_stays_low");
    cycle(1'b1, 1'b1, 8'h07, "modes_07");
    cycle(1'b1, 1'b1, 8'h01, "b2b_01");
    cycle(1'b1, 1'b1, 8'h03, "b2b_03");
    cycle(1'b1, 1'b1, 8'h07, "b2b_07");
    cycle(1'b1, 1'b1, 8'h1F, "w5_top_bits");
    cycle(1'b1, 1'b1, 8'hE0, "w5_ignored_bits");

    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic       ld;
      logic [7:0] d;
      r  = ($urandom_range(0, 15) != 0);
      ld = $urandom_range(0, 1) == 1;
      d  = 8'($urandom());
      cycle(r, ld, d, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
